// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for sram_ctrl.
// SRAM_CTRL_WR_RSP_EN adds an is_wr tag so write acks can travel through the response FIFO.
package sram_ctrl_pkg;

    localparam int unsigned RspDataWidth = 64;

    typedef struct packed {
`ifdef SRAM_CTRL_WR_RSP_EN
        logic                    is_wr;
`endif
        logic [RspDataWidth-1:0] data;
    } sram_rsp_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a completely full FIFO is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sram_if.sv
// Port bundle between the controller and the single-port SRAM macro wrapper.
// Signal names follow the macro's point of view.
interface sram_if #(
    parameter int unsigned BIT_WIDTH  = 64,
    parameter int unsigned WORD_DEPTH = 512
);
    import sram_ctrl_pkg::*;

    localparam int unsigned AW = addr_width(WORD_DEPTH);

    logic                   clk_i;
    logic                   en_i;
    logic                   wen_i;
    logic [BIT_WIDTH/8-1:0] bm_i;
    logic [AW-1:0]          addr_i;
    logic [BIT_WIDTH-1:0]   dat_i;
    logic [BIT_WIDTH-1:0]   dat_o;

    modport slave (output clk_i, en_i, wen_i, bm_i, addr_i, dat_i, input dat_o);
    modport macro (input clk_i, en_i, wen_i, bm_i, addr_i, dat_i, output dat_o);

endinterface

// File: rtl/sram_rsp_fifo.sv
// Synchronous FIFO holding read responses; pointers wrap naturally, count is one bit wider.
module sram_rsp_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64,
    localparam int unsigned PW = $clog2(Depth),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam logic [CW-1:0] DepthC = CW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == DepthC);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready front-end for a single-port SRAM; a read is accepted only when its response slot
// is already reserved. Define SRAM_CTRL_WR_RSP_EN to make every write return an ack (data 0).
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = RspDataWidth,
    parameter int unsigned WORD_DEPTH = 512,
    parameter int unsigned RSP_DEPTH  = 4,
    localparam int unsigned AW = addr_width(WORD_DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [BIT_WIDTH/8-1:0] req_bm_i,
    input  logic [AW-1:0]          req_addr_i,
    input  logic [BIT_WIDTH-1:0]   req_dat_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [BIT_WIDTH-1:0]   rsp_dat_o,
    sram_if.slave                  sram
);
    localparam int unsigned CW = cnt_width(RSP_DEPTH);
    localparam logic [CW:0] CreditMax = (CW + 1)'(RSP_DEPTH);

    // The response entry type is sized by the package.
    if (BIT_WIDTH != RspDataWidth) begin : g_width_check
        $error("sram_ctrl: BIT_WIDTH must equal sram_ctrl_pkg::RspDataWidth");
    end

    logic          accept, rsp_req, inflight_q;
    logic          push, pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credit_sum;
    sram_rsp_t     push_ent, head_ent;

    // Credits count both stored responses and the one still coming out of the macro.
    assign credit_sum  = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_q};
    assign req_ready_o = (credit_sum < CreditMax);
    assign accept      = req_valid_i && req_ready_o;

`ifdef SRAM_CTRL_WR_RSP_EN
    logic wr_q;

    assign rsp_req = accept;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wr_q <= 1'b0;
        else          wr_q <= accept && req_we_i;
    end

    always_comb begin
        push_ent       = '0;
        push_ent.is_wr = wr_q;
        push_ent.data  = wr_q ? '0 : sram.dat_o;
    end

    assign rsp_dat_o = (rsp_valid_o && !head_ent.is_wr) ? head_ent.data : '0;
`else
    assign rsp_req = accept && !req_we_i;

    always_comb begin
        push_ent      = '0;
        push_ent.data = sram.dat_o;
    end

    assign rsp_dat_o = rsp_valid_o ? head_ent.data : '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) inflight_q <= 1'b0;
        else          inflight_q <= rsp_req;
    end

    assign push        = inflight_q;
    assign rsp_valid_o = !fifo_empty;
    assign pop         = rsp_valid_o && rsp_ready_i;

    sram_rsp_fifo #(
        .Depth (RSP_DEPTH),
        .Width ($bits(sram_rsp_t))
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_ent),
        .rdata_o (head_ent),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && fifo_full && !pop));

    assign sram.clk_i = clk_i;

    always_comb begin
        sram.en_i   = 1'b0;
        sram.wen_i  = 1'b0;
        sram.bm_i   = '0;
        sram.addr_i = '0;
        sram.dat_i  = '0;
        if (accept) begin
            sram.en_i   = 1'b1;
            sram.wen_i  = req_we_i;
            sram.bm_i   = req_we_i ? req_bm_i : '1;
            sram.addr_i = req_addr_i;
            sram.dat_i  = req_dat_i;
        end
    end

endmodule
